cdp_dp_rdma_unpack: RTL

//  Directly downstream of the CDP read DMA. Accepts the 41-bit packets the CDP RDMA egress drives on cdp_rdma2dp_*.

---
 rtl/cdp_dp_pkg.sv | 25 ++
 rtl/cdp_dp_skid2.sv | 52 +++++
 rtl/cdp_dp_rdma_unpack.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cdp_dp_pkg.sv
// Shared encodings for the CDP datapath unpack stage.
// Covers the input data modes, the packet field offsets, the FSM states and the element width.
package cdp_dp_pkg;

    typedef enum logic [1:0] {
        INPUT_INT8  = 2'd0,
        INPUT_INT16 = 2'd1,
        INPUT_FP16  = 2'd2
    } input_data_t;

    localparam int PD_DATA_LSB  = 0;
    localparam int PD_MASK_LSB  = 16;
    localparam int PD_LINE_END  = 18;
    localparam int PD_SURF_END  = 19;
    localparam int PD_LAYER_END = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DP_ELEM_W = 19;

endpackage

// File: rtl/cdp_dp_skid2.sv
// Two-entry valid/ready skid FIFO that holds whole RDMA packets ahead of the serialiser.
module cdp_dp_skid2 #(
    parameter int W = 41
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    assign push_ready = (cnt != 2'd2);
    assign pop_valid  = (cnt != 2'd0);
    assign pop_data   = mem[rd_ptr];
    assign count      = cnt;
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                cnt <= cnt + 2'd1;
            end else if (pop && !push) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/cdp_dp_rdma_unpack.sv
// Unpacks CDP RDMA packets into single datapath elements and tracks the layer-end marker.
// The stall counter dp2reg_perf_stall exists only when CDP_UNPACK_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for reg2dp_op_load; input closed
// RUN   | accepting packets and emitting elements
// DONE  | layer-end element consumed; dp2reg_done high for this one cycle
module cdp_dp_rdma_unpack
    import cdp_dp_pkg::*;
#(
    parameter int EW     = 8,
    parameter int PKT_W  = 41,
    parameter int SKID_D = 2
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic [1:0]           reg2dp_input_data,
    input  logic                 reg2dp_op_load,
    input  logic                 cdp_rdma2dp_valid,
    output logic                 cdp_rdma2dp_ready,
    input  logic [PKT_W-1:0]     cdp_rdma2dp_pd,
    output logic                 dp_elem_valid,
    input  logic                 dp_elem_ready,
    output logic [DP_ELEM_W-1:0] dp_elem_pd,
    output logic                 dp2reg_done,
    output logic                 unpack_err
`ifdef CDP_UNPACK_PERF_EN
    ,
    output logic [31:0]          dp2reg_perf_stall
`endif
);
    state_t           state;
    state_t           state_nxt;
    logic [1:0]       mode_q;
    logic             ready_q;
    logic             ready_nxt;
    logic             closed_q;
    logic             closed_nxt;
    logic             idx_q;
    logic             err_q;

    logic             head_valid;
    logic [PKT_W-1:0] head;
    logic [1:0]       skid_count;
    logic [1:0]       count_nxt;
    logic             skid_room;

    logic             push;
    logic             pop;
    logic             drop;
    logic             accept;
    logic             last;
    logic             pair;
    logic             sel_hi;
    logic             is_int8;
    logic [1:0]       head_mask;
    logic [2*EW-1:0]  head_data;
    logic [2*EW-1:0]  elem_data;
    logic [EW-1:0]    byte_sel;
    logic [2:0]       head_flags;
    logic             unused_rsvd;

    assign push = cdp_rdma2dp_valid & ready_q & skid_room;

    cdp_dp_skid2 #(.W(PKT_W)) u_skid (
        .clk        (nvdla_core_clk),
        .rst_n      (nvdla_core_rstn),
        .push_valid (push),
        .push_ready (skid_room),
        .push_data  (cdp_rdma2dp_pd),
        .pop_valid  (head_valid),
        .pop_ready  (pop),
        .pop_data   (head),
        .count      (skid_count)
    );

    assign head_data   = head[PD_DATA_LSB +: 2*EW];
    assign head_mask   = head[PD_MASK_LSB +: 2];
    assign head_flags  = head[PD_LAYER_END:PD_LINE_END];
    assign unused_rsvd = ^head[PKT_W-1:PD_LAYER_END+1];

    // Only int8 splits a packet; the reserved mode code behaves as int16.
    assign is_int8  = (mode_q == INPUT_INT8);
    assign pair     = is_int8 && (head_mask == 2'b11);
    assign sel_hi   = pair ? idx_q : head_mask[1];
    assign byte_sel = sel_hi ? head_data[2*EW-1:EW] : head_data[EW-1:0];
    assign elem_data = is_int8 ? {{EW{byte_sel[EW-1]}}, byte_sel} : head_data;
    assign last     = !pair || idx_q;

    assign dp_elem_valid = head_valid && (head_mask != 2'b00);
    assign dp_elem_pd    = dp_elem_valid ? {(last ? head_flags : 3'b000), elem_data} : '0;
    assign accept        = dp_elem_valid & dp_elem_ready;
    assign drop          = head_valid && (head_mask == 2'b00);
    assign pop           = drop || (accept && last);

    always_comb begin
        count_nxt = skid_count;
        if (push && !pop) begin
            count_nxt = skid_count + 2'd1;
        end else if (pop && !push) begin
            count_nxt = skid_count - 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (reg2dp_op_load) state_nxt = RUN;
            RUN:     if (pop && head[PD_LAYER_END]) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Once the layer-end packet is taken nothing more enters until the next op_load.
    always_comb begin
        closed_nxt = closed_q;
        if (state == IDLE && reg2dp_op_load) begin
            closed_nxt = 1'b0;
        end else if (push && cdp_rdma2dp_pd[PD_LAYER_END]) begin
            closed_nxt = 1'b1;
        end
    end

    assign ready_nxt = (state_nxt == RUN) && (count_nxt != 2'(SKID_D)) && !closed_nxt;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= IDLE;
            mode_q   <= 2'd0;
            ready_q  <= 1'b0;
            closed_q <= 1'b0;
            idx_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_q  <= ready_nxt;
            closed_q <= closed_nxt;
            err_q    <= drop;
            if (state == IDLE && reg2dp_op_load) begin
                mode_q <= reg2dp_input_data;
            end
            if (pop) begin
                idx_q <= 1'b0;
            end else if (accept) begin
                idx_q <= 1'b1;
            end
        end
    end

    assign cdp_rdma2dp_ready = ready_q;
    assign dp2reg_done       = (state == DONE);
    assign unpack_err        = err_q;

`ifdef CDP_UNPACK_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_q <= '0;
        end else if (state == IDLE && reg2dp_op_load) begin
            stall_q <= '0;
        end else if (state != IDLE && dp_elem_valid && !dp_elem_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign dp2reg_perf_stall = stall_q;
`endif

endmodule
